// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator for the LED bank.
// One shared period counter feeds CHANNELS duty comparators. Edge-aligned
// (sawtooth) or center-aligned (up/down) counting. Top, duty and mode are
// double-buffered: writes land in pending registers and are copied to the
// active set at each period boundary, or continuously while idle.
//
// Ports:
//   clkl        system clock, rising edge
//   rst         synchronous reset, active low
//   en          run enable; low returns to IDLE and abandons the period
//   center      0 edge-aligned, 1 center-aligned (taken at a boundary)
//   top_wr      strobe: top_data -> pending top
//   top_data    new counter top value
//   duty_wr     strobe: duty_data -> pending duty[duty_ch]
//   duty_ch     target channel; values >= CHANNELS are ignored
//   duty_data   new duty value
//   signal      registered PWM outputs
//   period_end  registered pulse in the first output cycle of each period
//   dir         registered counting direction (1 = counting down)
module pwm_multi #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned CH_W        = 3,
    parameter int unsigned DEFAULT_TOP = 255
) (
    input  logic                clkl,
    input  logic                rst,
    input  logic                en,
    input  logic                center,
    input  logic                top_wr,
    input  logic [WIDTH-1:0]    top_data,
    input  logic                duty_wr,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [WIDTH-1:0]    duty_data,
    output logic [CHANNELS-1:0] signal,
    output logic                period_end,
    output logic                dir
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] DOWN = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic [WIDTH-1:0]               top_act_q, top_act_d;
    logic [WIDTH-1:0]               top_pend_q, top_pend_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_act_q, duty_act_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic                           mode_act_q, mode_act_d;
    logic [CHANNELS-1:0]            signal_q, signal_d;
    logic                           period_end_q, period_end_d;
    logic                           dir_q, dir_d;

    logic                           boundary_c;
    logic                           run_c;
    logic [WIDTH-1:0]               top_eff_c;
    logic                           mode_eff_c;

    // A new period starts whenever the running counter sits at zero.
    assign boundary_c = (state_q != IDLE) && (cnt_q == '0);
    assign run_c      = en && (state_q != IDLE);

    // The boundary cycle already steers the counter with the incoming
    // period's top and mode, so the new period has its full length.
    assign top_eff_c  = boundary_c ? top_pend_q : top_act_q;
    assign mode_eff_c = boundary_c ? center     : mode_act_q;

    // Pending registers take strobes; active registers reload from pending.
    always_comb begin
        top_pend_d  = top_pend_q;
        duty_pend_d = duty_pend_q;
        top_act_d   = top_act_q;
        duty_act_d  = duty_act_q;
        mode_act_d  = mode_act_q;

        if (top_wr) begin
            top_pend_d = top_data;
        end
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (duty_wr && (duty_ch == CH_W'(i))) begin
                duty_pend_d[i] = duty_data;
            end
        end

        if ((state_q == IDLE) || boundary_c) begin
            top_act_d  = top_pend_q;
            duty_act_d = duty_pend_q;
            mode_act_d = center;
        end
    end

    // Period counter and direction state machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = UP;
                end
            end
            UP: begin
                if (cnt_q >= top_eff_c) begin
                    if (mode_eff_c && (top_eff_c != '0)) begin
                        state_d = DOWN;
                        cnt_d   = top_eff_c - WIDTH'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            DOWN: begin
                if (cnt_q == '0) begin
                    state_d = UP;
                    // A zero top for the next period keeps the counter parked at 0.
                    cnt_d   = (top_eff_c == '0) ? '0 : WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Output stage; a falling enable forces idle outputs on the next cycle.
    always_comb begin
        signal_d     = '0;
        period_end_d = 1'b0;
        dir_d        = 1'b0;
        if (run_c) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                signal_d[i] = (cnt_q < duty_act_q[i]);
            end
            period_end_d = boundary_c;
            dir_d        = (state_q == DOWN);
        end
    end

    always_ff @(posedge clkl) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            top_act_q    <= WIDTH'(DEFAULT_TOP);
            top_pend_q   <= WIDTH'(DEFAULT_TOP);
            duty_act_q   <= '0;
            duty_pend_q  <= '0;
            mode_act_q   <= 1'b0;
            signal_q     <= '0;
            period_end_q <= 1'b0;
            dir_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            top_act_q    <= top_act_d;
            top_pend_q   <= top_pend_d;
            duty_act_q   <= duty_act_d;
            duty_pend_q  <= duty_pend_d;
            mode_act_q   <= mode_act_d;
            signal_q     <= signal_d;
            period_end_q <= period_end_d;
            dir_q        <= dir_d;
        end
    end

    assign signal     = signal_q;
    assign period_end = period_end_q;
    assign dir        = dir_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: per-period scoreboard on the 8-channel instance plus
// direct checks for reset, enable and a 4-bit / 3-channel instance.
module tb_pwm_multi;

    logic clkl = 1'b0;
    always #5 clkl = ~clkl;

    // Main instance (defaults)
    logic       rst, en, center, top_wr, duty_wr;
    logic [7:0] top_data, duty_data;
    logic [2:0] duty_ch;
    logic [7:0] signal;
    logic       period_end, dir;

    // Narrow instance
    logic       s_en, s_center, s_top_wr, s_duty_wr;
    logic [3:0] s_top_data, s_duty_data;
    logic [1:0] s_duty_ch;
    logic [2:0] s_signal;
    logic       s_period_end, s_dir;

    pwm_multi dut (
        .clkl(clkl), .rst(rst), .en(en), .center(center),
        .top_wr(top_wr), .top_data(top_data),
        .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_data(duty_data),
        .signal(signal), .period_end(period_end), .dir(dir)
    );

    pwm_multi #(.WIDTH(4), .CHANNELS(3), .CH_W(2), .DEFAULT_TOP(15)) dut_s (
        .clkl(clkl), .rst(rst), .en(s_en), .center(s_center),
        .top_wr(s_top_wr), .top_data(s_top_data),
        .duty_wr(s_duty_wr), .duty_ch(s_duty_ch), .duty_data(s_duty_data),
        .signal(s_signal), .period_end(s_period_end), .dir(s_dir)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One observed or expected period: length, ch0 waveform, high counts of
    // ch1..ch3 and the dir waveform (bit k = k-th cycle after period_end).
    typedef struct {
        int          len;
        logic [31:0] p0;
        int          c1;
        int          c2;
        int          c3;
        logic [31:0] pd;
    } per_t;

    per_t exp_q[$];
    per_t cur;
    logic mon_on  = 1'b0;
    logic in_prog = 1'b0;

    function automatic per_t mk(input int len, input logic [31:0] p0, input int c1,
                                input int c2, input int c3, input logic [31:0] pd);
        per_t r;
        r.len = len; r.p0 = p0; r.c1 = c1; r.c2 = c2; r.c3 = c3; r.pd = pd;
        return r;
    endfunction

    // Period monitor: each period_end closes the running period and pops one expectation.
    always @(negedge clkl) begin
        if (mon_on) begin
            if (period_end) begin
                if (in_prog) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        per_t e;
                        e = exp_q.pop_front();
                        check_eq("per_len", 32'(cur.len), 32'(e.len));
                        check_eq("per_ch0_wave", cur.p0, e.p0);
                        check_eq("per_ch1_high", 32'(cur.c1), 32'(e.c1));
                        check_eq("per_ch2_high", 32'(cur.c2), 32'(e.c2));
                        check_eq("per_ch3_high", 32'(cur.c3), 32'(e.c3));
                        check_eq("per_dir_wave", cur.pd, e.pd);
                    end
                end
                in_prog = 1'b1;
                cur = mk(0, '0, 0, 0, 0, '0);
            end
            if (in_prog) begin
                cur.p0 = cur.p0 | (32'(signal[0]) << cur.len);
                cur.pd = cur.pd | (32'(dir) << cur.len);
                cur.c1 = cur.c1 + int'(signal[1]);
                cur.c2 = cur.c2 + int'(signal[2]);
                cur.c3 = cur.c3 + int'(signal[3]);
                cur.len = cur.len + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clkl);
        #1;
    endtask

    task automatic wr_top(input logic [7:0] v);
        top_wr = 1'b1; top_data = v;
        tick();
        top_wr = 1'b0;
    endtask

    task automatic wr_duty(input logic [2:0] ch, input logic [7:0] v);
        duty_wr = 1'b1; duty_ch = ch; duty_data = v;
        tick();
        duty_wr = 1'b0;
    endtask

    task automatic s_wr_duty(input logic [1:0] ch, input logic [3:0] v);
        s_duty_wr = 1'b1; s_duty_ch = ch; s_duty_data = v;
        tick();
        s_duty_wr = 1'b0;
    endtask

    // Returns in the first cycle of the period that follows the last expected one.
    task automatic wait_empty(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clkl);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq(tag, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_out(input string tag);
        check_eq({tag, "_signal"}, 32'(signal), 32'd0);
        check_eq({tag, "_pend"}, 32'(period_end), 32'd0);
        check_eq({tag, "_dir"}, 32'(dir), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v16, n, hi0, hi1, hi2, pes, xb;
        rst = 1'b0; en = 1'b0; center = 1'b0;
        top_wr = 1'b0; top_data = '0; duty_wr = 1'b0; duty_ch = '0; duty_data = '0;
        s_en = 1'b0; s_center = 1'b0; s_top_wr = 1'b0; s_top_data = '0;
        s_duty_wr = 1'b0; s_duty_ch = '0; s_duty_data = '0;

        // Reset for 3 cycles; a duty strobe during reset must be dropped.
        tick();
        duty_wr = 1'b1; duty_ch = 3'd3; duty_data = 8'd50;
        tick();
        duty_wr = 1'b0;
        tick();
        check_idle_out("reset");
        check_eq("reset_s_signal", 32'(s_signal), 32'd0);
        rst = 1'b1;

        // Edge mode: top 9, duties 3 / 0 / 10 (above top).
        wr_top(8'd9);
        wr_duty(3'd0, 8'd3);
        wr_duty(3'd1, 8'd0);
        wr_duty(3'd2, 8'd10);
        check_idle_out("idle_pre");
        repeat (3) exp_q.push_back(mk(10, 32'h7, 0, 10, 0, 32'h0));
        mon_on = 1'b1;
        en = 1'b1;
        wait_empty(60, "edge_timeout");

        // Mid-period duty change: current period keeps 3, next shows 7.
        exp_q.push_back(mk(10, 32'h7, 0, 10, 0, 32'h0));
        exp_q.push_back(mk(10, 32'h7F, 0, 10, 0, 32'h0));
        repeat (3) tick();
        wr_duty(3'd0, 8'd7);
        wr_top(8'd9);
        wait_empty(60, "shadow_timeout");

        // Write strobed in the boundary cycle lands one period later.
        exp_q.push_back(mk(10, 32'h7F, 0, 10, 0, 32'h0));
        exp_q.push_back(mk(10, 32'h7F, 0, 10, 0, 32'h0));
        exp_q.push_back(mk(10, 32'h1F, 0, 10, 0, 32'h0));
        repeat (9) tick();
        wr_duty(3'd0, 8'd5);
        wait_empty(60, "bwrite_timeout");

        // Switch to center mode, top 4, ch0 duty 2.
        exp_q.push_back(mk(10, 32'h1F, 0, 10, 0, 32'h0));
        exp_q.push_back(mk(8, 32'h83, 0, 8, 0, 32'hE0));
        exp_q.push_back(mk(8, 32'h83, 0, 8, 0, 32'hE1));
        exp_q.push_back(mk(8, 32'h83, 0, 8, 0, 32'hE1));
        center = 1'b1;
        tick();
        wr_top(8'd4);
        wr_duty(3'd0, 8'd2);
        wait_empty(80, "center_timeout");

        // top 0 with duty 1: one-cycle periods, output constantly high.
        exp_q.push_back(mk(8, 32'h83, 0, 8, 0, 32'hE1));
        exp_q.push_back(mk(1, 32'h1, 0, 1, 0, 32'h1));
        repeat (4) exp_q.push_back(mk(1, 32'h1, 0, 1, 0, 32'h0));
        wr_top(8'd0);
        wr_duty(3'd0, 8'd1);
        wait_empty(40, "top0_timeout");

        // Disable, reprogram edge mode in IDLE, restart.
        mon_on = 1'b0; in_prog = 1'b0;
        tick();
        en = 1'b0;
        @(negedge clkl);
        @(negedge clkl);
        check_idle_out("disable");
        tick();
        center = 1'b0;
        wr_top(8'd9);
        wr_duty(3'd0, 8'd3);
        exp_q.push_back(mk(10, 32'h7, 0, 10, 0, 32'h0));
        mon_on = 1'b1;
        en = 1'b1;
        wait_empty(40, "restart_timeout");

        // Drop enable at cnt 5.
        repeat (4) tick();
        mon_on = 1'b0; in_prog = 1'b0;
        en = 1'b0;
        @(negedge clkl);
        @(negedge clkl);
        check_idle_out("en_drop");

        // Re-raise: period_end two cycles later with cnt restarting at 0.
        exp_q.push_back(mk(10, 32'h7, 0, 10, 0, 32'h0));
        mon_on = 1'b1;
        tick();
        en = 1'b1;
        @(negedge clkl);
        check_eq("reraise_pend_c0", 32'(period_end), 32'd0);
        @(negedge clkl);
        check_eq("reraise_pend_c1", 32'(period_end), 32'd0);
        @(negedge clkl);
        check_eq("reraise_pend_c2", 32'(period_end), 32'd1);
        check_eq("reraise_signal", 32'(signal), 32'h05);
        check_eq("reraise_dir", 32'(dir), 32'd0);
        wait_empty(40, "reraise_timeout");

        // Reset mid-period; a top write in the reset cycle is ignored.
        repeat (3) tick();
        mon_on = 1'b0; in_prog = 1'b0;
        rst = 1'b0;
        top_wr = 1'b1; top_data = 8'd3;
        tick();
        top_wr = 1'b0;
        check_idle_out("mid_reset");
        en = 1'b0;
        tick();
        rst = 1'b1;
        wr_duty(3'd2, 8'd200);
        exp_q.push_back(mk(256, 32'h0, 0, 200, 0, 32'h0));
        mon_on = 1'b1;
        en = 1'b1;
        wait_empty(700, "deftop_timeout");
        mon_on = 1'b0;
        en = 1'b0;

        // Narrow instance: top 15, duties 15 / 16 (wraps to 0) / 9, bad channel.
        v16 = 16;
        s_top_wr = 1'b1; s_top_data = 4'd15;
        tick();
        s_top_wr = 1'b0;
        s_wr_duty(2'd0, 4'd15);
        s_wr_duty(2'd1, 4'(v16));
        s_wr_duty(2'd2, 4'd9);
        s_wr_duty(2'd3, 4'd1);
        s_en = 1'b1;
        n = 0;
        while (!s_period_end && n < 40) begin
            @(negedge clkl);
            n++;
        end
        check_eq("sw_start", 32'(s_period_end), 32'd1);
        hi0 = 0; hi1 = 0; hi2 = 0; pes = 0; xb = 0;
        for (int k = 0; k < 16; k++) begin
            hi0 += int'(s_signal[0]);
            hi1 += int'(s_signal[1]);
            hi2 += int'(s_signal[2]);
            pes += int'(s_period_end);
            xb  += int'($isunknown({s_signal, s_period_end, s_dir}));
            @(negedge clkl);
        end
        check_eq("sw_ch0_high", 32'(hi0), 32'd15);
        check_eq("sw_ch1_high", 32'(hi1), 32'd0);
        check_eq("sw_ch2_high", 32'(hi2), 32'd9);
        check_eq("sw_pend_count", 32'(pes), 32'd1);
        check_eq("sw_next_pend", 32'(s_period_end), 32'd1);
        check_eq("sw_x", 32'(xb), 32'd0);
        check_eq("main_x", 32'($isunknown({signal, period_end, dir})), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
